vector_pe_sequencer: RTL and testbench

- Sequences one vector_processing_element (PE) over a full vector operation: accepts a command, walks the 32-bit words of the source/destination vector registers, and feeds each word to the PE.
- Per word it reads vs1/vs2/vd from the vector register file (VRF), drives the PE start/done handshake, and writes peout back to vd.
- Sits between the vector decode stage and the PE.

---
 rtl/vector_pe_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_vector_pe_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_pe_sequencer.sv
// Walks the words of a vector operation: reads vs1/vs2/vd words from the VRF, hands each
// word to a processing element via a start/done handshake, and writes the result back to vd.
module vector_pe_sequencer #(
    parameter int WORDS_PER_REG = 8,
    parameter int REG_W         = 5,
    parameter int RF_AW         = 8,
    parameter int VL_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_instr,
    input  logic [9:0]       cmd_sew,
    input  logic [3:0]       cmd_vap,
    input  logic [VL_W-1:0]  cmd_vl,
    input  logic [REG_W-1:0] cmd_vs1,
    input  logic [REG_W-1:0] cmd_vs2,
    input  logic [REG_W-1:0] cmd_vd,
    output logic             rf_rd_en,
    output logic [RF_AW-1:0] rf_rd_addr_a,
    output logic [RF_AW-1:0] rf_rd_addr_b,
    output logic [RF_AW-1:0] rf_rd_addr_c,
    input  logic [31:0]      rf_rd_data_a,
    input  logic [31:0]      rf_rd_data_b,
    input  logic [31:0]      rf_rd_data_c,
    output logic             rf_wr_en,
    output logic [RF_AW-1:0] rf_wr_addr,
    output logic [31:0]      rf_wr_data,
    output logic [7:0]       pe_instr,
    output logic [9:0]       pe_sew,
    output logic [3:0]       pe_vap,
    output logic             pe_start,
    output logic [31:0]      pe_opA,
    output logic [31:0]      pe_opB,
    output logic [31:0]      pe_opC,
    input  logic             pe_done,
    input  logic [31:0]      pe_out,
    output logic             busy,
    output logic             resp_valid,
    output logic             resp_err
);

    localparam int IDX_W = (WORDS_PER_REG > 1) ? $clog2(WORDS_PER_REG) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_EXEC,
        S_WB,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         instr_q, instr_d;
    logic [9:0]         sew_q, sew_d;
    logic [3:0]         vap_q, vap_d;
    logic [REG_W-1:0]   vs1_q, vs1_d;
    logic [REG_W-1:0]   vs2_q, vs2_d;
    logic [REG_W-1:0]   vd_q, vd_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               err_q, err_d;
    logic [31:0]        opa_q, opa_d;
    logic [31:0]        opb_q, opb_d;
    logic [31:0]        opc_q, opc_d;
    logic [31:0]        res_q, res_d;

    function automatic logic [RF_AW-1:0] word_addr(input logic [REG_W-1:0] r,
                                                   input logic [IDX_W-1:0] i);
        return RF_AW'(r) * RF_AW'(WORDS_PER_REG) + RF_AW'(i);
    endfunction

    // Command decode: elements per word is a power of two, so ceil(vl/epw) is a rounded shift.
    logic           is_varp, sew_ok, vap_ok, too_long, cmd_err;
    logic [1:0]     epw_sh;
    logic [VL_W:0]  epw_round, nwords;

    always_comb begin
        is_varp = (cmd_instr == 8'd3) || (cmd_instr == 8'd4) || (cmd_instr == 8'd5);
        sew_ok  = (cmd_sew == 10'd8) || (cmd_sew == 10'd16) || (cmd_sew == 10'd32);
        vap_ok  = (cmd_vap == 4'd1) || (cmd_vap == 4'd2) || (cmd_vap == 4'd4) || (cmd_vap == 4'd8);
        if (is_varp || cmd_sew == 10'd8) begin
            epw_sh    = 2'd2;
            epw_round = (VL_W+1)'(3);
        end else if (cmd_sew == 10'd16) begin
            epw_sh    = 2'd1;
            epw_round = (VL_W+1)'(1);
        end else begin
            epw_sh    = 2'd0;
            epw_round = '0;
        end
        nwords   = ({1'b0, cmd_vl} + epw_round) >> epw_sh;
        too_long = nwords > (VL_W+1)'(WORDS_PER_REG);
        cmd_err  = (cmd_instr > 8'd7) || (is_varp ? !vap_ok : !sew_ok) || too_long;
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        sew_d        = sew_q;
        vap_d        = vap_q;
        vs1_d        = vs1_q;
        vs2_d        = vs2_q;
        vd_d         = vd_q;
        idx_d        = idx_q;
        last_d       = last_q;
        err_d        = err_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        opc_d        = opc_q;
        res_d        = res_q;
        cmd_ready    = 1'b0;
        rf_rd_en     = 1'b0;
        rf_rd_addr_a = '0;
        rf_rd_addr_b = '0;
        rf_rd_addr_c = '0;
        rf_wr_en     = 1'b0;
        rf_wr_addr   = '0;
        rf_wr_data   = '0;
        pe_start     = 1'b0;
        resp_valid   = 1'b0;
        resp_err     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    instr_d = cmd_instr;
                    sew_d   = cmd_sew;
                    vap_d   = cmd_vap;
                    vs1_d   = cmd_vs1;
                    vs2_d   = cmd_vs2;
                    vd_d    = cmd_vd;
                    idx_d   = '0;
                    last_d  = IDX_W'(nwords - 1'b1);
                    err_d   = cmd_err;
                    // Errors and empty vectors answer immediately without touching VRF or PE.
                    if (cmd_err || cmd_vl == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                rf_rd_en     = 1'b1;
                rf_rd_addr_a = word_addr(vs1_q, idx_q);
                rf_rd_addr_b = word_addr(vs2_q, idx_q);
                rf_rd_addr_c = word_addr(vd_q, idx_q);
                state_d      = S_CAP;
            end
            S_CAP: begin
                opa_d   = rf_rd_data_a;
                opb_d   = rf_rd_data_b;
                opc_d   = rf_rd_data_c;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pe_start = 1'b1;
                if (pe_done) begin
                    res_d   = pe_out;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // pe_start is low here, which also releases the PE before the next word.
                rf_wr_en   = 1'b1;
                rf_wr_addr = word_addr(vd_q, idx_q);
                rf_wr_data = res_q;
                if (idx_q == last_q) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_FIN: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            sew_q   <= '0;
            vap_q   <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            vd_q    <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            sew_q   <= sew_d;
            vap_q   <= vap_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            vd_q    <= vd_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            err_q   <= err_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
            res_q   <= res_d;
        end
    end

    assign pe_instr = instr_q;
    assign pe_sew   = sew_q;
    assign pe_vap   = vap_q;
    assign pe_opA   = opa_q;
    assign pe_opB   = opb_q;
    assign pe_opC   = opc_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_vector_pe_sequencer.sv
// Bench for vector_pe_sequencer: VRF and PE models, a queue-based reference, and a monitor.
module tb_vector_pe_sequencer;

    localparam int WPR   = 8;
    localparam int REG_W = 5;
    localparam int RF_AW = 8;
    localparam int VL_W  = 8;

    logic             clk, reset, cmd_valid, cmd_ready;
    logic [7:0]       cmd_instr;
    logic [9:0]       cmd_sew;
    logic [3:0]       cmd_vap;
    logic [VL_W-1:0]  cmd_vl;
    logic [REG_W-1:0] cmd_vs1, cmd_vs2, cmd_vd;
    logic             rf_rd_en, rf_wr_en;
    logic [RF_AW-1:0] rf_rd_addr_a, rf_rd_addr_b, rf_rd_addr_c, rf_wr_addr;
    logic [31:0]      rf_rd_data_a, rf_rd_data_b, rf_rd_data_c, rf_wr_data;
    logic [7:0]       pe_instr;
    logic [9:0]       pe_sew;
    logic [3:0]       pe_vap;
    logic             pe_start, pe_done, busy, resp_valid, resp_err;
    logic [31:0]      pe_opA, pe_opB, pe_opC, pe_out;

    vector_pe_sequencer #(.WORDS_PER_REG(WPR), .REG_W(REG_W), .RF_AW(RF_AW), .VL_W(VL_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_sew(cmd_sew), .cmd_vap(cmd_vap), .cmd_vl(cmd_vl),
        .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
        .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_addr_c(rf_rd_addr_c), .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .rf_rd_data_c(rf_rd_data_c), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .pe_instr(pe_instr), .pe_sew(pe_sew), .pe_vap(pe_vap),
        .pe_start(pe_start), .pe_opA(pe_opA), .pe_opB(pe_opB), .pe_opC(pe_opC),
        .pe_done(pe_done), .pe_out(pe_out), .busy(busy), .resp_valid(resp_valid),
        .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behaviour of the PE: lane-wise add/mul/sub (truncated), dot = opC + sum of lane products.
    function automatic logic [31:0] pe_fn(input logic [7:0] op, input int w,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
        logic [31:0] r   = '0;
        logic [31:0] acc = c;
        logic [31:0] m   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        logic [31:0] la, lb, v;
        for (int i = 0; i < 32 / w; i++) begin
            la = (a >> (i * w)) & m;
            lb = (b >> (i * w)) & m;
            case (op)
                8'd1, 8'd4: v = (la * lb) & m;
                8'd6, 8'd7: v = (la - lb) & m;
                default:    v = (la + lb) & m;
            endcase
            r = r | (v << (i * w));
            acc = acc + la * lb;
        end
        return (op == 8'd2 || op == 8'd5) ? acc : r;
    endfunction

    function automatic int lane_w(input logic [7:0] op, input logic [9:0] sew);
        return (op == 8'd3 || op == 8'd4 || op == 8'd5) ? 8 : int'(sew);
    endfunction

    // VRF model: one-cycle read latency; bench preload port shares the write path.
    logic [31:0]      mem [0:255];
    logic [31:0]      rd_a, rd_b, rd_c;
    logic             tb_wr_en = 1'b0;
    logic [RF_AW-1:0] tb_wr_addr = '0;
    logic [31:0]      tb_wr_data = '0;
    always @(posedge clk) begin
        if (rf_rd_en) begin
            rd_a <= mem[rf_rd_addr_a];
            rd_b <= mem[rf_rd_addr_b];
            rd_c <= mem[rf_rd_addr_c];
        end
        if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
        if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
    end
    assign rf_rd_data_a = rd_a;
    assign rf_rd_data_b = rd_b;
    assign rf_rd_data_c = rd_c;

    // PE model: variable latency, done held while start is held.
    logic        pe_act = 1'b0;
    logic        pe_dn = 1'b0;
    int          pe_cnt = 0;
    logic [31:0] pe_res = '0;
    always @(posedge clk) begin
        if (!pe_start) begin
            pe_act <= 1'b0;
            pe_dn  <= 1'b0;
        end else if (!pe_act) begin
            pe_act <= 1'b1;
            pe_res <= pe_fn(pe_instr, lane_w(pe_instr, pe_sew), pe_opA, pe_opB, pe_opC);
            if (pe_instr == 8'd1 || pe_instr == 8'd4)
                pe_cnt <= (lane_w(pe_instr, pe_sew) == 32) ? 34 :
                          (lane_w(pe_instr, pe_sew) == 16) ? 17 : 9;
            else
                pe_cnt <= int'($urandom_range(1, 4));
        end else if (pe_cnt > 1) begin
            pe_cnt <= pe_cnt - 1;
        end else begin
            pe_dn <= 1'b1;
        end
    end
    assign pe_done = pe_dn;
    assign pe_out  = pe_dn ? pe_res : 32'hDEAD_BEEF;

    typedef struct { logic [RF_AW-1:0] a, b, c; } rd_t;
    typedef struct { logic [RF_AW-1:0] addr; logic [31:0] data; logic [31:0] old; } wr_t;
    typedef struct { logic err; int cyc; } rsp_t;

    rd_t  rq[$];
    wr_t  wq[$];
    rsp_t pq[$];
    logic [31:0] shadow [0:255];
    logic [7:0]  cur_instr;
    logic [9:0]  cur_sew;
    logic [3:0]  cur_vap;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows VRF traffic, a start, or a response.
    bit prev_start = 1'b0;
    bit prev_done  = 1'b0;
    always @(negedge clk) begin
        rd_t  r;
        wr_t  w;
        rsp_t p;
        if (mon_en) begin
            if (rf_rd_en) begin
                if (rq.size() == 0) chk(1'b0, "unexpected_read", 32'(rf_rd_addr_a), 32'hFFFF_FFFF);
                else begin
                    r = rq.pop_front();
                    chk({rf_rd_addr_a, rf_rd_addr_b, rf_rd_addr_c} == {r.a, r.b, r.c}, "rd_addr",
                        32'({rf_rd_addr_a, rf_rd_addr_b, rf_rd_addr_c}), 32'({r.a, r.b, r.c}));
                end
            end
            if (rf_wr_en) begin
                if (wq.size() == 0) chk(1'b0, "unexpected_write", 32'(rf_wr_addr), 32'hFFFF_FFFF);
                else begin
                    w = wq.pop_front();
                    chk(rf_wr_addr == w.addr, "wr_addr", 32'(rf_wr_addr), 32'(w.addr));
                    chk(rf_wr_data == w.data, "wr_data", rf_wr_data, w.data);
                end
            end
            if (pe_start && !prev_start) begin
                chk(wq.size() != 0, "start_without_work", 32'(pe_start), 32'd0);
                chk({pe_instr, pe_sew, pe_vap} == {cur_instr, cur_sew, cur_vap}, "pe_fields",
                    32'({pe_instr, pe_sew, pe_vap}), 32'({cur_instr, cur_sew, cur_vap}));
            end
            if (prev_start && prev_done) chk(!pe_start, "start_after_done", 32'(pe_start), 32'd0);
            if (resp_valid) begin
                if (pq.size() == 0) chk(1'b0, "unexpected_resp", 32'(resp_err), 32'hFFFF_FFFF);
                else begin
                    p = pq.pop_front();
                    chk(resp_err == p.err, "resp_err", 32'(resp_err), 32'(p.err));
                    if (p.cyc >= 0) chk(cyc == p.cyc, "resp_cycle", 32'(cyc), 32'(p.cyc));
                    chk(rq.size() == 0 && wq.size() == 0, "resp_before_writes",
                        32'(wq.size()), 32'd0);
                end
            end
        end
        prev_start = pe_start;
        prev_done  = pe_done;
    end

    task automatic poke(input logic [RF_AW-1:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        tb_wr_en   = 1'b1;
        tb_wr_addr = addr;
        tb_wr_data = data;
        shadow[addr] = data;
        @(posedge clk);
        #1;
        tb_wr_en = 1'b0;
    endtask

    // Offers a command, and at acceptance pushes the expected reads, writes and response.
    task automatic issue(input logic [7:0] op, input logic [9:0] sew, input logic [3:0] vap,
                         input int vl, input int vs1, input int vs2, input int vd);
        bit  varp, err, acc;
        int  epw, nw, w;
        wr_t e;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_instr = op;
        cmd_sew   = sew;
        cmd_vap   = vap;
        cmd_vl    = VL_W'(vl);
        cmd_vs1   = REG_W'(vs1);
        cmd_vs2   = REG_W'(vs2);
        cmd_vd    = REG_W'(vd);
        acc = 1'b0;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
        end
        if (!acc) begin
            chk(1'b0, "cmd_accept_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            varp = (op == 8'd3 || op == 8'd4 || op == 8'd5);
            err  = (op > 8'd7) || (varp ? !(vap inside {4'd1, 4'd2, 4'd4, 4'd8})
                                        : !(sew inside {10'd8, 10'd16, 10'd32}));
            epw  = varp ? 4 : (sew == 10'd32) ? 1 : (sew == 10'd16) ? 2 : 4;
            nw   = (vl + epw - 1) / epw;
            if (nw > WPR) err = 1'b1;
            cur_instr = op;
            cur_sew   = sew;
            cur_vap   = vap;
            if (err || vl == 0) begin
                pq.push_back('{err: err, cyc: cyc + 1});
            end else begin
                w = lane_w(op, sew);
                for (int i = 0; i < nw; i++) begin
                    rq.push_back('{a: RF_AW'(vs1 * WPR + i), b: RF_AW'(vs2 * WPR + i),
                                   c: RF_AW'(vd * WPR + i)});
                    e.addr = RF_AW'(vd * WPR + i);
                    e.old  = shadow[e.addr];
                    e.data = pe_fn(op, w, shadow[RF_AW'(vs1 * WPR + i)],
                                   shadow[RF_AW'(vs2 * WPR + i)], e.old);
                    wq.push_back(e);
                    shadow[e.addr] = e.data;
                end
                pq.push_back('{err: 1'b0, cyc: -1});
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_instr = 8'($urandom);
        cmd_sew   = 10'($urandom);
        cmd_vl    = VL_W'($urandom);
        cmd_vd    = REG_W'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (pq.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(pq.size() == 0, "completion_timeout", 32'(pq.size()), 32'd0);
        @(posedge clk);
    endtask

    task automatic random_cmd();
        logic [7:0] op;
        logic [9:0] sew;
        logic [3:0] vap;
        int         vl;
        op = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0:       sew = 10'($urandom_range(0, 1023));
            1, 2, 3: sew = 10'd8;
            4, 5, 6: sew = 10'd16;
            default: sew = 10'd32;
        endcase
        case ($urandom_range(0, 9))
            0:       vap = 4'($urandom);
            1, 2:    vap = 4'd1;
            3, 4:    vap = 4'd2;
            5, 6:    vap = 4'd4;
            default: vap = 4'd8;
        endcase
        vl = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 40));
        issue(op, sew, vap, vl, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)));
        wait_done();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_instr = '0;
        cmd_sew = '0;
        cmd_vap = '0;
        cmd_vl = '0;
        cmd_vs1 = '0;
        cmd_vs2 = '0;
        cmd_vd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(cmd_ready == 1'b1, "reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);
        chk({rf_rd_en, rf_wr_en, pe_start, resp_valid, resp_err} == 5'b0, "reset_strobes",
            32'({rf_rd_en, rf_wr_en, pe_start, resp_valid, resp_err}), 32'd0);
        chk({pe_opA, pe_instr, pe_sew, pe_vap} == '0, "reset_pe_outputs", pe_opA, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            tb_wr_en   = 1'b1;
            tb_wr_addr = RF_AW'(i);
            tb_wr_data = $urandom;
            shadow[i]  = tb_wr_data;
        end
        @(posedge clk);
        #1;
        tb_wr_en = 1'b0;
        mon_en = 1'b1;

        // vadd SEW32: {1,2,3} + {10,20,30}
        for (int i = 0; i < 3; i++) begin
            poke(RF_AW'(1 * WPR + i), 32'(i + 1));
            poke(RF_AW'(2 * WPR + i), 32'(10 * (i + 1)));
        end
        issue(8'd0, 10'd32, 4'd1, 3, 1, 2, 3);
        wait_done();
        chk(shadow[3 * WPR + 2] == 32'd33, "vadd_ref_word2", shadow[3 * WPR + 2], 32'd33);

        // vmul SEW16 with wraparound in the low lane
        poke(RF_AW'(4 * WPR), 32'h0003_FFFE);
        poke(RF_AW'(5 * WPR), 32'h0005_0002);
        issue(8'd1, 10'd16, 4'd1, 4, 4, 5, 6);
        wait_done();

        // vdot SEW8 accumulates into the preloaded vd word
        issue(8'd2, 10'd8, 4'd1, 5, 7, 8, 9);
        wait_done();

        // Errors and the empty vector
        issue(8'd0, 10'd12, 4'd1, 4, 1, 2, 3);
        wait_done();
        issue(8'd0, 10'd8, 4'd1, 40, 1, 2, 3);
        wait_done();
        issue(8'd4, 10'd32, 4'd3, 4, 1, 2, 3);
        wait_done();
        issue(8'd9, 10'd32, 4'd1, 1, 1, 2, 3);
        wait_done();
        issue(8'd0, 10'd32, 4'd1, 0, 1, 2, 3);
        wait_done();

        // Reset while word 1 of a 3-word vmul is executing
        issue(8'd1, 10'd32, 4'd1, 3, 10, 11, 12);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            found = pe_start && (wq.size() == 2);
        end
        chk(found, "abort_reach_word1", 32'(wq.size()), 32'd2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        while (wq.size() != 0) begin
            wr_t e;
            e = wq.pop_back();
            shadow[e.addr] = e.old;
        end
        rq.delete();
        pq.delete();
        reset = 1'b1;
        @(negedge clk);
        chk(pe_start == 1'b0, "abort_pe_start", 32'(pe_start), 32'd0);
        chk(busy == 1'b0, "abort_busy", 32'(busy), 32'd0);
        chk(cmd_ready == 1'b1, "abort_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (10) @(posedge clk);
        issue(8'd6, 10'd16, 4'd1, 6, 13, 14, 15);
        wait_done();

        for (int n = 0; n < 40; n++) random_cmd();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
